// File: rtl/adu_pkg.sv
// Shared readout state type, width helpers and the AW/DW parameter check for adu_bank.
`ifndef ADU_PKG_SV
`define ADU_PKG_SV

`define ADU_WIDTH_CHECK(aw, dw) \
    if ((((aw) % (dw)) != 0) || ((aw) < (dw))) begin : g_width_check \
        $error("adu: AW must be a nonzero multiple of DW"); \
    end

package adu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        STREAM = 2'd2
    } adu_state_e;

    function automatic int lanes(input int aw, input int dw);
        return aw / dw;
    endfunction

    function automatic int lane_w(input int aw, input int dw);
        return (aw / dw > 1) ? $clog2(aw / dw) : 1;
    endfunction

    function automatic int sel_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

`endif

// File: rtl/adu_ser.sv
// Readout serializer: holds a snapshot, presents it DW bits at a time under qv/qr,
// and strobes done on the edge that accepts the final lane.
module adu_ser import adu_pkg::*; #(
    parameter int AW = 16,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_lane,
    input  logic          ld_word,
    input  logic [DW-1:0] lane_data,
    input  logic [AW-1:0] word,
    input  logic          qr,
    output logic [DW-1:0] q,
    output logic          qv,
    output logic          done
);

    localparam int L  = lanes(AW, DW);
    localparam int LW = lane_w(AW, DW);
    localparam logic [LW-1:0] LAST = LW'(L - 1);

    logic [AW-1:0] sh;
    logic [LW-1:0] left;

    assign q    = sh[DW-1:0];
    assign done = qv && qr && (left == '0);

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh   <= '0;
            left <= '0;
            qv   <= 1'b0;
        end else if (ld_lane) begin
            sh   <= AW'(lane_data);
            left <= '0;
            qv   <= 1'b1;
        end else if (ld_word) begin
            sh   <= word;
            left <= LAST;
            qv   <= 1'b1;
        end else if (qv && qr) begin
            if (left == '0) begin
                qv <= 1'b0;
            end else begin
                sh   <= sh >> DW;
                left <= left - LW'(1);
            end
        end
    end

endmodule

// File: rtl/adu_bank.sv
// Multi-channel address register bank with lane/parallel load, post-inc/dec with
// wrap pulse, and a single-lane or whole-register readout over a narrow bus.
module adu_bank import adu_pkg::*; #(
    parameter int AW  = 16,
    parameter int DW  = 8,
    parameter int NCH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [sel_w(NCH)-1:0]     sel,
    input  logic [AW-1:0]             a,
    input  logic                      we,
    input  logic                      bw,
    input  logic [lane_w(AW,DW)-1:0]  lane,
    input  logic [DW-1:0]             d,
    input  logic                      inc,
    input  logic                      dec,
    input  logic                      rd,
    input  logic                      st,
    input  logic                      qr,
    output logic [DW-1:0]             q,
    output logic                      qv,
    output logic                      busy,
    output logic                      cy
);

    localparam int L  = lanes(AW, DW);
    localparam int LW = lane_w(AW, DW);

    `ADU_WIDTH_CHECK(AW, DW)

    if ((NCH < 2) || ((NCH & (NCH - 1)) != 0)) begin : g_nch_check
        $error("adu: NCH must be a power of two, at least 2");
    end

    logic [AW-1:0] regs [NCH];
    logic [AW-1:0] cur;
    logic [AW-1:0] nxt;
    logic          wrap;
    logic [DW-1:0] lane_data;
    adu_state_e    state;
    logic          start_rd;
    logic          start_st;
    logic          done;

    assign cur = regs[sel];

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        nxt  = cur;
        wrap = 1'b0;
        if (we) begin
            nxt = a;
        end else if (bw) begin
            for (int i = 0; i < L; i++) begin
                if (lane == LW'(i)) nxt[i*DW +: DW] = d;
            end
        end else if (inc && !dec) begin
            nxt  = cur + AW'(1);
            wrap = &cur;
        end else if (dec && !inc) begin
            nxt  = cur - AW'(1);
            wrap = (cur == '0);
        end
    end

    always_comb begin
        lane_data = '0;
        for (int i = 0; i < L; i++) begin
            if (lane == LW'(i)) lane_data = cur[i*DW +: DW];
        end
    end

    // NOTE: the bank is built from flops rather than RAM, so every entry is cleared on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) regs[i] <= '0;
            cy <= 1'b0;
        end else begin
            regs[sel] <= nxt;
            cy        <= wrap;
        end
    end

    // Requests are only looked at in IDLE; rd takes precedence over st.
    assign start_rd = (state == IDLE) && rd;
    assign start_st = (state == IDLE) && st && !rd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (rd)      state <= HOLD;
                    else if (st) state <= STREAM;
                end
                HOLD, STREAM: begin
                    if (done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

    adu_ser #(
        .AW (AW),
        .DW (DW)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .ld_lane   (start_rd),
        .ld_word   (start_st),
        .lane_data (lane_data),
        .word      (cur),
        .qr        (qr),
        .q         (q),
        .qv        (qv),
        .done      (done)
    );

endmodule

// File: tb/tb_adu_bank.sv
// Self-checking bench for adu_bank: directed sequences, a command table and a
// randomized run against a queue-based reference model.
module tb_adu_bank;

    localparam int AW  = 16;
    localparam int DW  = 8;
    localparam int NCH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  sel;
    logic [15:0] a;
    logic        we, bw, inc, dec, rd, st, qr;
    logic        lane;
    logic [7:0]  d;
    logic [7:0]  q;
    logic        qv, busy, cy;

    int n_tests = 0;
    int n_fail  = 0;

    adu_bank #(.AW(AW), .DW(DW), .NCH(NCH)) dut (
        .clk(clk), .rst(rst), .sel(sel), .a(a), .we(we), .bw(bw), .lane(lane),
        .d(d), .inc(inc), .dec(dec), .rd(rd), .st(st), .qr(qr),
        .q(q), .qv(qv), .busy(busy), .cy(cy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we, bw, inc, dec;
        logic [1:0]  sel;
        logic        lane;
        logic [15:0] a;
        logic [7:0]  d;
        logic [15:0] exp_val;
        logic        exp_cy;
    } vec_t;

    vec_t        tbl [11];
    logic [15:0] final_exp [4];
    logic [15:0] m_regs [4];
    logic [7:0]  m_q [$];
    logic        m_cy;
    logic [15:0] w;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; bw = 1'b0; inc = 1'b0; dec = 1'b0;
        rd = 1'b0; st = 1'b0; qr = 1'b0;
    endtask

    task automatic read_lane(input logic [1:0] s, input logic l, input logic [7:0] exp, input string name);
        sel = s; lane = l; rd = 1'b1; qr = 1'b1;
        cyc();
        rd = 1'b0;
        check({name, "_qv"}, qv, 1);
        check({name, "_q"}, q, exp);
        check({name, "_busy"}, busy, 1);
        cyc();
        check({name, "_qv_end"}, qv, 0);
        check({name, "_busy_end"}, busy, 0);
        idle();
    endtask

    task automatic read_word(input logic [1:0] s, output logic [15:0] word, input string name);
        sel = s; st = 1'b1; qr = 1'b1;
        cyc();
        st = 1'b0;
        check({name, "_qv0"}, qv, 1);
        check({name, "_busy0"}, busy, 1);
        word[7:0] = q;
        cyc();
        check({name, "_qv1"}, qv, 1);
        check({name, "_busy1"}, busy, 1);
        word[15:8] = q;
        cyc();
        check({name, "_qv_end"}, qv, 0);
        check({name, "_busy_end"}, busy, 0);
        idle();
    endtask

    initial begin
        idle();
        sel = 2'd0; lane = 1'b0; a = 16'h0; d = 8'h0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_q", q, 0);
        check("rst_qv", qv, 0);
        check("rst_busy", busy, 0);
        check("rst_cy", cy, 0);
        rst = 1'b1;
        cyc();

        // Parallel write then single-lane reads
        sel = 2'd0; a = 16'h7A0E; we = 1'b1;
        cyc();
        idle();
        read_lane(2'd0, 1'b0, 8'h0E, "rd_l0");
        read_lane(2'd0, 1'b1, 8'h7A, "rd_l1");

        // Full-rate stream
        read_word(2'd0, w, "st_full");
        check("st_full_word", w, 16'h7A0E);

        // Stalled stream with a concurrent write to the streamed channel
        sel = 2'd0; st = 1'b1; qr = 1'b0;
        cyc();
        st = 1'b0;
        check("stall_qv_a", qv, 1);
        check("stall_q_a", q, 8'h0E);
        we = 1'b1; a = 16'h4E20;
        cyc();
        we = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("stall_qv_%0d", i), qv, 1);
            check($sformatf("stall_q_%0d", i), q, 8'h0E);
            cyc();
        end
        check("stall_q_last", q, 8'h0E);
        qr = 1'b1;
        cyc();
        check("stall_lane1_qv", qv, 1);
        check("stall_lane1_q", q, 8'h7A);
        cyc();
        check("stall_done_qv", qv, 0);
        check("stall_done_busy", busy, 0);
        idle();
        read_lane(2'd0, 1'b1, 8'h4E, "post_stall_rd");

        // Command table: modify, check cy pulse, read the channel back
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 16'hFFFF, 8'h00, 16'hFFFF, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 16'h0000, 8'h00, 16'h0000, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 16'h0000, 8'h00, 16'hFFFF, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 16'h0000, 8'h00, 16'hFFFF, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 16'h0020, 8'h00, 16'h0020, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 16'h0000, 8'h4E, 16'h4E20, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 16'h1234, 8'hAA, 16'h1234, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 16'hFFFF, 8'h00, 16'hFFFF, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 16'h0000, 8'h00, 16'h0000, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 16'h0000, 8'h05, 16'h4E05, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 16'h0000, 8'h00, 16'h4E04, 1'b0};

        foreach (tbl[i]) begin
            we = tbl[i].we; bw = tbl[i].bw; inc = tbl[i].inc; dec = tbl[i].dec;
            sel = tbl[i].sel; lane = tbl[i].lane; a = tbl[i].a; d = tbl[i].d;
            cyc();
            idle();
            check($sformatf("tbl%0d_cy", i), cy, tbl[i].exp_cy);
            cyc();
            check($sformatf("tbl%0d_cy_end", i), cy, 0);
            read_word(tbl[i].sel, w, $sformatf("tbl%0d_rd", i));
            check($sformatf("tbl%0d_val", i), w, tbl[i].exp_val);
        end

        final_exp = '{16'h4E04, 16'hFFFF, 16'h4E20, 16'h0000};
        for (int c = 0; c < 4; c++) begin
            read_word(2'(c), w, $sformatf("iso%0d_rd", c));
            check($sformatf("iso%0d_val", c), w, final_exp[c]);
        end

        // Randomized run against the reference model
        m_regs = final_exp;
        m_q.delete();
        for (int it = 0; it < 400; it++) begin
            int r;
            sel  = 2'($urandom_range(0, 3));
            lane = 1'($urandom_range(0, 1));
            d    = 8'($urandom);
            case ($urandom_range(0, 2))
                0:       a = 16'h0000;
                1:       a = 16'hFFFF;
                default: a = 16'($urandom);
            endcase
            r   = $urandom_range(0, 9);
            we  = (r == 0);
            bw  = (r == 1) || (r == 7);
            inc = (r == 2) || (r == 3) || (r == 4);
            dec = (r == 4) || (r == 5) || (r == 6) || (r == 7);
            rd  = ($urandom_range(0, 3) == 0);
            st  = ($urandom_range(0, 3) == 0);
            qr  = ($urandom_range(0, 2) != 0);

            if (m_q.size() != 0) begin
                if (qr) void'(m_q.pop_front());
            end else if (rd) begin
                m_q.push_back(m_regs[sel][int'(lane)*8 +: 8]);
            end else if (st) begin
                m_q.push_back(m_regs[sel][7:0]);
                m_q.push_back(m_regs[sel][15:8]);
            end

            m_cy = 1'b0;
            if (we) begin
                m_regs[sel] = a;
            end else if (bw) begin
                m_regs[sel][int'(lane)*8 +: 8] = d;
            end else if (inc && !dec) begin
                m_cy = (m_regs[sel] == 16'hFFFF);
                m_regs[sel] = m_regs[sel] + 16'd1;
            end else if (dec && !inc) begin
                m_cy = (m_regs[sel] == 16'h0000);
                m_regs[sel] = m_regs[sel] - 16'd1;
            end

            cyc();
            check($sformatf("rnd%0d_qv", it), qv, (m_q.size() != 0));
            check($sformatf("rnd%0d_busy", it), busy, (m_q.size() != 0));
            check($sformatf("rnd%0d_cy", it), cy, m_cy);
            if (m_q.size() != 0) check($sformatf("rnd%0d_q", it), q, m_q[0]);
        end
        idle();
        qr = 1'b1;
        cyc();
        cyc();
        check("drain_busy", busy, 0);
        idle();

        // Reset in the middle of a stream, after lane 0 was accepted
        sel = 2'd0; a = 16'hABCD; we = 1'b1;
        cyc();
        idle();
        sel = 2'd0; st = 1'b1; qr = 1'b1;
        cyc();
        st = 1'b0;
        check("mid_lane0_q", q, 8'hCD);
        cyc();
        check("mid_lane1_q", q, 8'hAB);
        check("mid_lane1_qv", qv, 1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_q", q, 0);
        check("mid_rst_qv", qv, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cy", cy, 0);
        rst = 1'b1;
        cyc();
        check("mid_after_qv", qv, 0);
        idle();
        for (int c = 0; c < 4; c++) begin
            read_lane(2'(c), 1'b0, 8'h00, $sformatf("clr%0d_l0", c));
            read_lane(2'(c), 1'b1, 8'h00, $sformatf("clr%0d_l1", c));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
